// File: rtl/jdecoder_mon.sv
// jdecoder_mon: decodes a sampled Johnson code to an index and a one-hot vector,
// and tracks whether successive samples step through the 2*WIDTH-state sequence.
// A LOCKED/UNLOCKED state machine reports sequence breaks while locked and keeps
// a saturating count of them.
module jdecoder_mon #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8
) (
  input  logic                         in_clk,
  input  logic                         in_clr_n,
  input  logic                         in_en,
  input  logic [WIDTH-1:0]             in_q,
  input  logic                         in_err_clr,
  output logic [$clog2(2*WIDTH)-1:0]   o_idx,
  output logic [2*WIDTH-1:0]           o_onehot,
  output logic                         o_valid,
  output logic                         o_locked,
  output logic                         o_err,
  output logic [ERRW-1:0]              o_err_cnt
);

  localparam int IW = $clog2(2*WIDTH);
  localparam logic [IW-1:0]   LAST    = IW'(2*WIDTH-1);
  localparam logic [IW-1:0]   IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [3:0]      LOCK_C  = 4'(LOCK_CNT);
  localparam logic [ERRW-1:0] CNT_MAX = {ERRW{1'b1}};
  localparam logic [ERRW-1:0] CNT_ONE = {{(ERRW-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] OH_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Number of ones in the sampled code.
  function automatic logic [IW-1:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [IW-1:0] c;
    c = {IW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(IW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // A Johnson code has at most one boundary between runs of ones and zeros.
  function automatic logic f_legal(input logic [WIDTH-1:0] v);
    logic [IW-1:0] t;
    t = {IW{1'b0}};
    for (int i = 1; i < WIDTH; i++) begin
      t = t + {{(IW-1){1'b0}}, v[i] ^ v[i-1]};
    end
    return (t <= IDX_ONE);
  endfunction

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [2*WIDTH-1:0]  r_onehot, w_onehot_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_err, w_err_nxt;
  logic [ERRW-1:0]     r_err_cnt, w_err_cnt_nxt;
  logic [IW-1:0]       r_ref, w_ref_nxt;
  logic                r_ref_vld, w_ref_vld_nxt;
  logic [3:0]          r_good, w_good_nxt;

  logic                w_legal;
  logic [IW-1:0]       w_pop;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_ref_inc;
  logic                w_step_ok;

  // Decode the current code and judge it against the reference index.
  always_comb begin
    w_legal   = f_legal(in_q);
    w_pop     = f_popcount(in_q);
    w_idx     = {IW{1'b0}};
    w_ref_inc = (r_ref == LAST) ? {IW{1'b0}} : (r_ref + IDX_ONE);
    if (!w_legal) begin
      w_idx = {IW{1'b0}};
    end else if (in_q[0]) begin
      // 2*WIDTH - pop, written so no intermediate needs an extra bit
      w_idx = (LAST - w_pop) + IDX_ONE;
    end else begin
      w_idx = w_pop;
    end
    w_step_ok = w_legal && r_ref_vld && (w_idx == w_ref_inc);
  end

  // Next-state and next-output logic for the lock tracker.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_onehot_nxt  = r_onehot;
    w_valid_nxt   = r_valid;
    w_err_nxt     = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_ref_nxt     = r_ref;
    w_ref_vld_nxt = r_ref_vld;
    w_good_nxt    = r_good;

    if (in_en) begin
      w_idx_nxt     = w_idx;
      w_onehot_nxt  = w_legal ? (OH_ONE << w_idx) : {(2*WIDTH){1'b0}};
      w_valid_nxt   = w_legal;
      w_ref_vld_nxt = w_legal;
      w_ref_nxt     = w_legal ? w_idx : r_ref;

      case (r_state)
        ST_UNLOCKED: begin
          if (w_step_ok) begin
            if ((r_good + 4'd1) >= LOCK_C) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = 4'd0;
            end else begin
              w_good_nxt  = r_good + 4'd1;
            end
          end else begin
            // also covers the first legal sample, which only seeds the reference
            w_good_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (w_step_ok) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt   = ST_UNLOCKED;
            w_good_nxt    = 4'd0;
            w_err_nxt     = 1'b1;
            w_err_cnt_nxt = (r_err_cnt == CNT_MAX) ? CNT_MAX : (r_err_cnt + CNT_ONE);
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_good_nxt  = 4'd0;
        end
      endcase
    end else begin
      w_err_nxt = 1'b0;
    end

    // Clear wins over a concurrent increment; the o_err pulse is unaffected.
    if (in_err_clr) begin
      w_err_cnt_nxt = {ERRW{1'b0}};
    end else begin
      w_err_cnt_nxt = w_err_cnt_nxt;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge in_clk or negedge in_clr_n) begin
    if (!in_clr_n) begin
      r_state   <= ST_UNLOCKED;
      r_idx     <= {IW{1'b0}};
      r_onehot  <= {(2*WIDTH){1'b0}};
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= {ERRW{1'b0}};
      r_ref     <= {IW{1'b0}};
      r_ref_vld <= 1'b0;
      r_good    <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_onehot  <= w_onehot_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_ref     <= w_ref_nxt;
      r_ref_vld <= w_ref_vld_nxt;
      r_good    <= w_good_nxt;
    end
  end

  assign o_idx     = r_idx;
  assign o_onehot  = r_onehot;
  assign o_valid   = r_valid;
  assign o_locked  = (r_state == ST_LOCKED);
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_jdecoder_mon.sv
`timescale 1ns/100ps
// Directed bench for jdecoder_mon with WIDTH=4, LOCK_CNT=3, ERRW=8.
module tb_jdecoder_mon;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic [3:0] q;
  logic       err_clr;
  logic [2:0] idx;
  logic [7:0] onehot;
  logic       valid;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int n_checks;
  int n_fail;

  jdecoder_mon #(.WIDTH(4), .LOCK_CNT(3), .ERRW(8)) dut (
    .in_clk     (clk),
    .in_clr_n   (clr_n),
    .in_en      (en),
    .in_q       (q),
    .in_err_clr (err_clr),
    .o_idx      (idx),
    .o_onehot   (onehot),
    .o_valid    (valid),
    .o_locked   (locked),
    .o_err      (err),
    .o_err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] q;
    logic       clr;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       v;
    logic       l;
    logic       e;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];
  logic [3:0] codes [8];

  function automatic vec_t mk(logic e_n, logic [3:0] qq, logic c, logic [2:0] i,
                              logic [7:0] o, logic vv, logic ll, logic ee, logic [7:0] cc);
    vec_t r;
    r.en = e_n; r.q = qq; r.clr = c; r.idx = i; r.oh = o;
    r.v = vv; r.l = ll; r.e = ee; r.cnt = cc;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ei, input logic [7:0] eo,
                         input logic ev, input logic el, input logic ee, input logic [7:0] ec);
    chk({tag, ".idx"},    int'(idx),     int'(ei));
    chk({tag, ".onehot"}, int'(onehot),  int'(eo));
    chk({tag, ".valid"},  int'(valid),   int'(ev));
    chk({tag, ".locked"}, int'(locked),  int'(el));
    chk({tag, ".err"},    int'(err),     int'(ee));
    chk({tag, ".errcnt"}, int'(err_cnt), int'(ec));
  endtask

  // Drive one sample between edges; return just after the capturing edge.
  task automatic apply(input logic e_n, input logic [3:0] qq, input logic c);
    @(negedge clk);
    en = e_n; q = qq; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    logic [7:0] exp_cnt;
    n_checks = 0;
    n_fail   = 0;
    codes[0] = 4'b0000; codes[1] = 4'b1000; codes[2] = 4'b1100; codes[3] = 4'b1110;
    codes[4] = 4'b1111; codes[5] = 4'b0111; codes[6] = 4'b0011; codes[7] = 4'b0001;

    //             en    q        clr   idx   onehot  v     l     e     cnt
    vt.push_back(mk(1'b1, 4'b0000, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b1000, 1'b0, 3'd1, 8'h02, 1'b1, 1'b0, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b1100, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b1110, 1'b0, 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b1111, 1'b0, 3'd4, 8'h10, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b0111, 1'b0, 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b0011, 1'b0, 3'd6, 8'h40, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b0001, 1'b0, 3'd7, 8'h80, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b0000, 1'b0, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b0, 4'b1010, 1'b0, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b1000, 1'b0, 3'd1, 8'h02, 1'b1, 1'b1, 1'b0, 8'd0));
    vt.push_back(mk(1'b1, 4'b1010, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1));
    vt.push_back(mk(1'b0, 4'b1100, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b0100, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b1100, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b1110, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b1111, 1'b0, 3'd4, 8'h10, 1'b1, 1'b0, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b0111, 1'b0, 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b0011, 1'b0, 3'd6, 8'h40, 1'b1, 1'b1, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b0001, 1'b0, 3'd7, 8'h80, 1'b1, 1'b1, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b0000, 1'b0, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b1000, 1'b0, 3'd1, 8'h02, 1'b1, 1'b1, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b1100, 1'b0, 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 8'd1));
    vt.push_back(mk(1'b1, 4'b1100, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b1, 8'd2));
    vt.push_back(mk(1'b1, 4'b1110, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0, 1'b0, 8'd2));
    vt.push_back(mk(1'b1, 4'b1111, 1'b0, 3'd4, 8'h10, 1'b1, 1'b0, 1'b0, 8'd2));
    vt.push_back(mk(1'b1, 4'b0111, 1'b0, 3'd5, 8'h20, 1'b1, 1'b1, 1'b0, 8'd2));

    en = 1'b0; q = 4'b0000; err_clr = 1'b0; clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].en, vt[i].q, vt[i].clr);
      chk_all($sformatf("vec%0d", i), vt[i].idx, vt[i].oh, vt[i].v, vt[i].l, vt[i].e, vt[i].cnt);
    end

    // Saturation: repeat the current code (error), then three steps to relock.
    cur = 5;
    exp_cnt = 8'd2;
    for (int n = 0; n < 254; n++) begin
      apply(1'b1, codes[cur], 1'b0);
      exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      chk($sformatf("sat%0d.err", n), int'(err), 1);
      chk($sformatf("sat%0d.cnt", n), int'(err_cnt), int'(exp_cnt));
      for (int k = 1; k <= 3; k++) begin
        cur = (cur + 1) % 8;
        apply(1'b1, codes[cur], 1'b0);
      end
      chk($sformatf("sat%0d.relock", n), int'(locked), 1);
    end
    chk("sat.final", int'(err_cnt), 255);

    // Clear concurrent with an error: pulse still seen, count dropped.
    apply(1'b1, codes[cur], 1'b1);
    chk("clr_conc.err", int'(err), 1);
    chk("clr_conc.cnt", int'(err_cnt), 0);
    chk("clr_conc.locked", int'(locked), 0);
    for (int k = 1; k <= 3; k++) begin
      cur = (cur + 1) % 8;
      apply(1'b1, codes[cur], 1'b0);
    end
    chk("relock1", int'(locked), 1);
    apply(1'b1, codes[cur], 1'b0);
    chk("err_after_clr.cnt", int'(err_cnt), 1);
    for (int k = 1; k <= 3; k++) begin
      cur = (cur + 1) % 8;
      apply(1'b1, codes[cur], 1'b0);
    end
    chk("relock2", int'(locked), 1);
    cur = (cur + 1) % 8;
    apply(1'b1, codes[cur], 1'b1);
    chk("clr_plain.cnt", int'(err_cnt), 0);
    chk("clr_plain.err", int'(err), 0);
    chk("clr_plain.locked", int'(locked), 1);

    // Short asynchronous reset between edges while locked.
    @(negedge clk);
    en = 1'b0; err_clr = 1'b0;
    #2 clr_n = 1'b0;
    #0.5;
    chk_all("async_rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    #0.5 clr_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, codes[k], 1'b0);
      chk($sformatf("rst_relock%0d.idx", k), int'(idx), k);
      chk($sformatf("rst_relock%0d.locked", k), int'(locked), (k == 3) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
